// File: rtl/unpacker.sv
// unpacker: read-side decompression stage for activation memory.
// Fetches packed 16-bit lane masks and packed nonzero-byte words, and rebuilds
// one dense 16x8-bit activation word per mask. Work proceeds in groups of 16
// masks (two mask words). Each group's encoded stream starts on a word boundary,
// and its last encoded word is zero-padded.
//
// Optional feature, enabled by defining UNPACKER_PAD_CHECK_EN:
//   pad_error is raised when the bytes discarded at the end of a group are not
//   all zero, or when 16 or more bytes are left over at that point (over-read).
//   The flag holds until reset or the next accepted start. When the macro is
//   not defined, pad_error is tied to 0.
//
// Handshake (dense_valid / dense_ready): a word transfers on any cycle where
// both signals are high. Once dense_valid rises, it stays high and dense_out
// stays constant until that transfer occurs.
//
// Address counters are kept at port width, so they wrap exactly like a wider
// counter truncated to the port.

module unpacker #(
  parameter int IO_DATA_WIDTH    = 8,
  parameter int MEM_BW           = 128,
  parameter int ADDR_WIDTH_ACT   = 14,
  parameter int ADDR_WIDTH_MASKS = 11
) (
  input  logic                        clk,
  input  logic                        arst_n_in,
  input  logic                        start_unpacker,
  input  logic [7:0]                  num_groups,
  output logic                        ready_unpacker,
  output logic                        done_unpacker,
  output logic                        masks_read_en,
  output logic [ADDR_WIDTH_MASKS-1:0] masks_read_addr,
  input  logic [MEM_BW-1:0]           masks_rdata,
  output logic                        encoded_read_en,
  output logic [ADDR_WIDTH_ACT-1:0]   encoded_read_addr,
  input  logic [MEM_BW-1:0]           encoded_rdata,
  output logic                        dense_valid,
  input  logic                        dense_ready,
  output logic [MEM_BW-1:0]           dense_out,
  output logic                        pad_error,
  output logic [2:0]                  fsm_state_dbg
);

  localparam int LANES      = MEM_BW / IO_DATA_WIDTH;  // lanes per word (16)
  localparam int BUF_LANES  = 2 * LANES;               // byte buffer depth (32)
  localparam int MASKS_PW   = MEM_BW / LANES;          // masks per mask word (8)

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_MASKS  = 3'd1,
    S_CAP_MASKS = 3'd2,
    S_CHECK     = 3'd3,
    S_RD_ENC    = 3'd4,
    S_CAP_ENC   = 3'd5,
    S_EMIT      = 3'd6,
    S_FLUSH     = 3'd7
  } state_t;

  state_t state, state_nxt;

  logic [IO_DATA_WIDTH-1:0]    byte_buf  [BUF_LANES];
  logic [IO_DATA_WIDTH-1:0]    buf_app   [BUF_LANES];
  logic [IO_DATA_WIDTH-1:0]    buf_shift [BUF_LANES];
  logic [IO_DATA_WIDTH-1:0]    enc_byte  [LANES];
  logic [5:0]                  fill;
  logic [MEM_BW-1:0]           mask_word;
  logic [3:0]                  mask_idx;
  logic [ADDR_WIDTH_MASKS-1:0] mask_addr;
  logic [ADDR_WIDTH_ACT-1:0]   enc_addr;
  logic [7:0]                  group_cnt;
  logic [7:0]                  groups_q;
  logic [LANES-1:0]            cur_mask;
  logic [4:0]                  pop;
  logic [4:0]                  k;
  logic [MEM_BW-1:0]           dense_exp;
  logic                        last_group;

  // Select the mask for the current index and count its set bits.
  always_comb begin
    cur_mask = '0;
    for (int i = 0; i < MASKS_PW; i++) begin
      if (mask_idx[2:0] == 3'(i)) cur_mask = mask_word[MEM_BW-1-LANES*i -: LANES];
    end
    pop = '0;
    for (int i = 0; i < LANES; i++) pop = pop + {4'd0, cur_mask[i]};
  end

  // Expand buffered bytes into lanes: the k-th set bit takes buffer byte k.
  always_comb begin
    dense_exp = '0;
    k         = '0;
    for (int l = 0; l < LANES; l++) begin
      if (cur_mask[LANES-1-l]) begin
        dense_exp[MEM_BW-1-IO_DATA_WIDTH*l -: IO_DATA_WIDTH] = byte_buf[k];
        k = k + 5'd1;
      end
    end
  end

  // Buffer update candidates: append a fetched word at fill, or consume pop bytes.
  always_comb begin
    for (int i = 0; i < LANES; i++) enc_byte[i] = encoded_rdata[MEM_BW-1-IO_DATA_WIDTH*i -: IO_DATA_WIDTH];
    for (int j = 0; j < BUF_LANES; j++) begin
      buf_app[j] = byte_buf[j];
      if (j >= int'(fill) && j < int'(fill) + LANES) buf_app[j] = enc_byte[4'(j - int'(fill))];
      buf_shift[j] = '0;
      if (j + int'(pop) < BUF_LANES) buf_shift[j] = byte_buf[5'(j + int'(pop))];
    end
  end

  assign last_group = (group_cnt == groups_q - 8'd1);

  // State register.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Next-state and Moore/Mealy outputs.
  always_comb begin
    state_nxt       = state;
    ready_unpacker  = 1'b0;
    masks_read_en   = 1'b0;
    encoded_read_en = 1'b0;
    dense_valid     = 1'b0;
    done_unpacker   = 1'b0;
    dense_out       = '0;
    case (state)
      S_IDLE: begin
        ready_unpacker = 1'b1;
        if (start_unpacker) state_nxt = S_RD_MASKS;
      end
      S_RD_MASKS: begin
        masks_read_en = 1'b1;
        state_nxt     = S_CAP_MASKS;
      end
      S_CAP_MASKS: state_nxt = S_CHECK;
      S_CHECK: begin
        if ({1'b0, pop} > fill) state_nxt = S_RD_ENC;
        else                    state_nxt = S_EMIT;
      end
      S_RD_ENC: begin
        encoded_read_en = 1'b1;
        state_nxt       = S_CAP_ENC;
      end
      S_CAP_ENC: state_nxt = S_EMIT;
      S_EMIT: begin
        dense_valid = 1'b1;
        dense_out   = dense_exp;
        if (dense_ready) begin
          if (mask_idx == 4'd7)       state_nxt = S_RD_MASKS;
          else if (mask_idx == 4'd15) state_nxt = S_FLUSH;
          else                        state_nxt = S_CHECK;
        end
      end
      S_FLUSH: begin
        if (last_group) begin
          done_unpacker = 1'b1;
          state_nxt     = S_IDLE;
        end else begin
          state_nxt = S_RD_MASKS;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: counters, mask register and byte buffer.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      byte_buf  <= '{default: '0};
      fill      <= '0;
      mask_word <= '0;
      mask_idx  <= '0;
      mask_addr <= '0;
      enc_addr  <= '0;
      group_cnt <= '0;
      groups_q  <= 8'd1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_unpacker) begin
            byte_buf  <= '{default: '0};
            fill      <= '0;
            mask_idx  <= '0;
            mask_addr <= '0;
            enc_addr  <= '0;
            group_cnt <= '0;
            groups_q  <= (num_groups == 8'd0) ? 8'd1 : num_groups;
          end
        end
        S_RD_MASKS:  mask_addr <= mask_addr + 1'b1;
        S_CAP_MASKS: mask_word <= masks_rdata;
        S_RD_ENC:    enc_addr  <= enc_addr + 1'b1;
        S_CAP_ENC: begin
          byte_buf <= buf_app;
          fill     <= fill + 6'd16;
        end
        S_EMIT: begin
          if (dense_ready) begin
            byte_buf <= buf_shift;
            fill     <= fill - {1'b0, pop};
            mask_idx <= mask_idx + 4'd1;
          end
        end
        S_FLUSH: begin
          byte_buf  <= '{default: '0};
          fill      <= '0;
          group_cnt <= group_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign masks_read_addr   = mask_addr;
  assign encoded_read_addr = enc_addr;
  assign fsm_state_dbg     = state;

`ifdef UNPACKER_PAD_CHECK_EN
  logic pad_bad;
  logic pad_error_q;

  // Leftover bytes at group end must be zero padding, and fewer than one word.
  always_comb begin
    pad_bad = (fill >= 6'd16);
    for (int j = 0; j < BUF_LANES; j++) begin
      if (j < int'(fill) && byte_buf[j] != '0) pad_bad = 1'b1;
    end
  end

  // Sticky padding flag, cleared by an accepted start.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in)                             pad_error_q <= 1'b0;
    else if (state == S_IDLE && start_unpacker) pad_error_q <= 1'b0;
    else if (state == S_FLUSH && pad_bad)       pad_error_q <= 1'b1;
  end

  assign pad_error = pad_error_q;
`else
  assign pad_error = 1'b0;
`endif

endmodule

// File: tb/tb_unpacker.sv
// tb_unpacker: randomized self-checking bench for unpacker with memory models
// and a byte-stream reference model.

module tb_unpacker;

  localparam int W = 128;

`ifdef UNPACKER_PAD_CHECK_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          arst_n_in = 1'b0;
  logic          start_unpacker = 1'b0;
  logic [7:0]    num_groups = 8'd0;
  logic          ready_unpacker, done_unpacker;
  logic          masks_read_en, encoded_read_en;
  logic [10:0]   masks_read_addr;
  logic [13:0]   encoded_read_addr;
  logic [W-1:0]  masks_rdata = '0;
  logic [W-1:0]  encoded_rdata = '0;
  logic          dense_valid;
  logic          dense_ready = 1'b0;
  logic [W-1:0]  dense_out;
  logic          pad_error;
  logic [2:0]    fsm_state_dbg;

  // clock / reset
  always #5 clk = ~clk;

  unpacker dut (
    .clk               (clk),
    .arst_n_in         (arst_n_in),
    .start_unpacker    (start_unpacker),
    .num_groups        (num_groups),
    .ready_unpacker    (ready_unpacker),
    .done_unpacker     (done_unpacker),
    .masks_read_en     (masks_read_en),
    .masks_read_addr   (masks_read_addr),
    .masks_rdata       (masks_rdata),
    .encoded_read_en   (encoded_read_en),
    .encoded_read_addr (encoded_read_addr),
    .encoded_rdata     (encoded_rdata),
    .dense_valid       (dense_valid),
    .dense_ready       (dense_ready),
    .dense_out         (dense_out),
    .pad_error         (pad_error),
    .fsm_state_dbg     (fsm_state_dbg)
  );

  // memory images and scoreboard state
  logic [W-1:0] mask_mem [256];
  logic [W-1:0] enc_mem  [256];
  logic [15:0]  masks_arr [64];
  logic [W-1:0] exp_q [$];
  int           mask_log [$];
  int           enc_log [$];
  int           exp_enc_reads;
  int           exp_mask_reads;
  int           byte_mode;
  logic [7:0]   pad_byte;
  logic         exp_pad;
  int           n_vec = 0;
  int           n_err = 0;

  // one-cycle read latency memories, logging every issued address
  always @(posedge clk) begin
    if (masks_read_en) begin
      masks_rdata = mask_mem[masks_read_addr[7:0]];
      mask_log.push_back(int'(masks_read_addr));
    end
    if (encoded_read_en) begin
      encoded_rdata = enc_mem[encoded_read_addr[7:0]];
      enc_log.push_back(int'(encoded_read_addr));
    end
  end

  // Lay out memories from masks_arr and build the expected dense words.
  task automatic build_job(input int groups);
    int         ebase;
    int         total;
    int         nwords;
    int         ptr;
    logic [7:0] bq [$];
    logic [W-1:0] word;
    logic [W-1:0] d;
    logic [15:0]  m;
    ebase = 0;
    exp_q.delete();
    mask_log.delete();
    enc_log.delete();
    exp_enc_reads  = 0;
    exp_mask_reads = 2 * groups;
    exp_pad        = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mask_mem[i] = '0;
      enc_mem[i]  = '0;
    end
    for (int g = 0; g < groups; g++) begin
      total = 0;
      bq.delete();
      for (int i = 0; i < 16; i++) begin
        m = masks_arr[g*16+i];
        mask_mem[2*g + i/8][127-16*(i%8) -: 16] = m;
        total += $countones(m);
      end
      for (int j = 0; j < total; j++)
        bq.push_back(byte_mode == 0 ? 8'(j) : 8'($urandom_range(0, 255)));
      nwords = (total + 15) / 16;
      for (int w = 0; w < nwords; w++) begin
        word = '0;
        for (int b = 0; b < 16; b++)
          word[127-8*b -: 8] = (w*16 + b < total) ? bq[w*16+b] : pad_byte;
        enc_mem[ebase + w] = word;
      end
      if ((total % 16) != 0 && pad_byte != 8'd0) exp_pad = PAD_EN;
      ebase += nwords;
      exp_enc_reads += nwords;
      ptr = 0;
      for (int i = 0; i < 16; i++) begin
        m = masks_arr[g*16+i];
        d = '0;
        for (int l = 0; l < 16; l++) begin
          if (m[15-l]) begin
            d[127-8*l -: 8] = bq[ptr];
            ptr++;
          end
        end
        exp_q.push_back(d);
      end
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    arst_n_in = 1'b0;
    start_unpacker = 1'b0;
    dense_ready = 1'b0;
    @(negedge clk);
    arst_n_in = 1'b1;
  endtask

  // Run one job to completion and check every dense word and side effect.
  task automatic run_job(input logic [7:0] ng, input int ready_pct, input int stall_first);
    int           done_cnt;
    int           cyc;
    int           stall_left;
    logic         prev_stall;
    logic [W-1:0] prev_out;
    logic [13:0]  prev_ea;
    logic [10:0]  prev_ma;
    logic [W-1:0] e;
    done_cnt = 0;
    cyc = 0;
    stall_left = stall_first;
    prev_stall = 1'b0;
    prev_out = '0;
    prev_ea = '0;
    prev_ma = '0;
    @(negedge clk);
    num_groups = ng;
    start_unpacker = 1'b1;
    @(negedge clk);
    start_unpacker = 1'b0;
    n_vec++;
    if (pad_error !== 1'b0) begin
      n_err++;
      $display("FAIL pad_clear_on_start: got %b expected 0", pad_error);
    end
    while (done_cnt == 0 && cyc < 5000) begin
      if (prev_stall) begin
        n_vec++;
        if (dense_valid !== 1'b1 || dense_out !== prev_out ||
            encoded_read_addr !== prev_ea || masks_read_addr !== prev_ma) begin
          n_err++;
          $display("FAIL stall_hold: valid=%b out=%h ea=%0d ma=%0d expected valid=1 out=%h ea=%0d ma=%0d",
                   dense_valid, dense_out, encoded_read_addr, masks_read_addr, prev_out, prev_ea, prev_ma);
        end
      end
      if (done_unpacker === 1'b1) begin
        done_cnt++;
        n_vec++;
        if (exp_q.size() != 0) begin
          n_err++;
          $display("FAIL done_early: %0d words outstanding, expected 0", exp_q.size());
        end
      end
      if (dense_valid === 1'b1 && stall_left > 0) begin
        dense_ready = 1'b0;
        stall_left--;
      end else begin
        dense_ready = ($urandom_range(1, 100) <= ready_pct);
      end
      if (dense_valid === 1'b1 && dense_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_word: got %h expected no word", dense_out);
        end else begin
          e = exp_q.pop_front();
          if (dense_out !== e) begin
            n_err++;
            $display("FAIL dense_word: got %h expected %h", dense_out, e);
          end
        end
      end
      prev_stall = (dense_valid === 1'b1) && !dense_ready;
      prev_out = dense_out;
      prev_ea = encoded_read_addr;
      prev_ma = masks_read_addr;
      @(negedge clk);
      cyc++;
    end
    dense_ready = 1'b0;
    n_vec++;
    if (done_cnt == 0) begin
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles, %0d words outstanding", cyc, exp_q.size());
      reset_dut();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (done_unpacker !== 1'b0 || ready_unpacker !== 1'b1) begin
        n_err++;
        $display("FAIL idle_after_done: done=%b ready=%b expected done=0 ready=1", done_unpacker, ready_unpacker);
      end
      @(negedge clk);
    end
    n_vec++;
    if (enc_log.size() != exp_enc_reads || mask_log.size() != exp_mask_reads) begin
      n_err++;
      $display("FAIL read_counts: enc=%0d mask=%0d expected enc=%0d mask=%0d",
               enc_log.size(), mask_log.size(), exp_enc_reads, exp_mask_reads);
    end
    for (int i = 0; i < enc_log.size(); i++) begin
      n_vec++;
      if (enc_log[i] != i) begin
        n_err++;
        $display("FAIL enc_addr: read %0d got %0d expected %0d", i, enc_log[i], i);
      end
    end
    for (int i = 0; i < mask_log.size(); i++) begin
      n_vec++;
      if (mask_log[i] != i) begin
        n_err++;
        $display("FAIL mask_addr: read %0d got %0d expected %0d", i, mask_log[i], i);
      end
    end
    n_vec++;
    if (encoded_read_addr !== 14'(exp_enc_reads) || masks_read_addr !== 11'(exp_mask_reads)) begin
      n_err++;
      $display("FAIL final_addr: ea=%0d ma=%0d expected ea=%0d ma=%0d",
               encoded_read_addr, masks_read_addr, exp_enc_reads, exp_mask_reads);
    end
    n_vec++;
    if (pad_error !== exp_pad) begin
      n_err++;
      $display("FAIL pad_error: got %b expected %b", pad_error, exp_pad);
    end
  endtask

  task automatic test_reset();
    arst_n_in = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (ready_unpacker !== 1'b1 || done_unpacker !== 1'b0 || masks_read_en !== 1'b0 ||
        encoded_read_en !== 1'b0 || dense_valid !== 1'b0 || pad_error !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: ready=%b done=%b mre=%b ere=%b valid=%b pad=%b expected 1 0 0 0 0 0",
               ready_unpacker, done_unpacker, masks_read_en, encoded_read_en, dense_valid, pad_error);
    end
    n_vec++;
    if (dense_out !== '0 || masks_read_addr !== '0 || encoded_read_addr !== '0) begin
      n_err++;
      $display("FAIL reset_data: out=%h ma=%0d ea=%0d expected all 0", dense_out, masks_read_addr, encoded_read_addr);
    end
    arst_n_in = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < 16; i++) masks_arr[i] = 16'hFFFF;
    byte_mode = 0;
    pad_byte = 8'd0;
    build_job(1);
    run_job(8'd1, 100, 0);
  endtask

  task automatic test_all_zero();
    for (int i = 0; i < 16; i++) masks_arr[i] = 16'h0000;
    byte_mode = 1;
    pad_byte = 8'd0;
    build_job(1);
    run_job(8'd1, 70, 0);
  endtask

  task automatic test_partial();
    for (int i = 0; i < 16; i++) masks_arr[i] = 16'h0000;
    masks_arr[0] = 16'hFFC0;
    masks_arr[1] = 16'hFFC0;
    byte_mode = 0;
    pad_byte = 8'd0;
    build_job(1);
    run_job(8'd1, 100, 0);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 16; i++) masks_arr[i] = 16'($urandom);
    byte_mode = 1;
    pad_byte = 8'd0;
    build_job(1);
    run_job(8'd1, 100, 5);
  endtask

  task automatic test_two_groups();
    for (int i = 0; i < 32; i++) masks_arr[i] = 16'h0000;
    masks_arr[0]  = 16'hFFFF;
    masks_arr[1]  = 16'hF000;
    masks_arr[19] = 16'h0F0F;
    masks_arr[25] = 16'hFFF0;
    byte_mode = 1;
    pad_byte = 8'd0;
    build_job(2);
    run_job(8'd2, 80, 0);
  endtask

  task automatic test_groups_zero();
    for (int i = 0; i < 16; i++) masks_arr[i] = 16'($urandom) & 16'($urandom);
    byte_mode = 1;
    pad_byte = 8'd0;
    build_job(1);
    run_job(8'd0, 90, 0);
  endtask

  task automatic test_pad();
    for (int i = 0; i < 16; i++) masks_arr[i] = 16'h0000;
    masks_arr[3] = 16'h00FF;
    byte_mode = 1;
    pad_byte = 8'hA5;
    build_job(1);
    run_job(8'd1, 100, 0);
    pad_byte = 8'd0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 32; i++) masks_arr[i] = 16'($urandom);
    byte_mode = 1;
    pad_byte = 8'd0;
    build_job(2);
    @(negedge clk);
    num_groups = 8'd2;
    start_unpacker = 1'b1;
    @(negedge clk);
    start_unpacker = 1'b0;
    dense_ready = 1'b1;
    repeat (12) @(negedge clk);
    arst_n_in = 1'b0;
    #1;
    n_vec++;
    if (ready_unpacker !== 1'b1 || dense_valid !== 1'b0 || masks_read_addr !== '0 ||
        encoded_read_addr !== '0 || done_unpacker !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: ready=%b valid=%b ma=%0d ea=%0d done=%b expected 1 0 0 0 0",
               ready_unpacker, dense_valid, masks_read_addr, encoded_read_addr, done_unpacker);
    end
    dense_ready = 1'b0;
    @(negedge clk);
    arst_n_in = 1'b1;
    build_job(2);
    run_job(8'd2, 75, 0);
  endtask

  task automatic test_random();
    int groups;
    int sel;
    for (int r = 0; r < 6; r++) begin
      groups = $urandom_range(1, 3);
      for (int i = 0; i < groups*16; i++) begin
        sel = $urandom_range(0, 3);
        case (sel)
          0:       masks_arr[i] = 16'($urandom);
          1:       masks_arr[i] = 16'($urandom) & 16'($urandom);
          2:       masks_arr[i] = 16'h0000;
          default: masks_arr[i] = 16'hFFFF;
        endcase
      end
      byte_mode = 1;
      pad_byte = 8'd0;
      build_job(groups);
      run_job(8'(groups), $urandom_range(30, 100), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_all_zero();
    test_partial();
    test_stall();
    test_two_groups();
    test_groups_zero();
    test_pad();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
